// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the serial ALU: op encodings, the controller state
// enum and a small helper that says whether an op runs through the subtractor.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD  = 2'b00;
    localparam op_t OP_SUB  = 2'b01;
    localparam op_t OP_SLT  = 2'b10;
    localparam op_t OP_SLTU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Every op except ADD is computed as a + ~b + 1.
    function automatic logic op_is_sub(input op_t op);
        return op != OP_ADD;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple of full adders. One slice of the serial ALU.
//
// Ports:
//   a, b   : slice operands
//   cin    : carry into bit 0
//   sum    : slice sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow on the last slice)
// -----------------------------------------------------------------------------
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_alu.sv
// -----------------------------------------------------------------------------
// serial_alu
// Multi-cycle ADD / SUB / SLT / SLTU. Operands are latched on the accept edge
// and processed DIGIT bits per cycle, LSB slice first, with the carry held in a
// register between slices. Result and flags appear WIDTH/DIGIT cycles after
// the accept edge and are held until the consumer takes them.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (in_ready high only in IDLE)
//   op, a, b            : operation and operands, sampled only on accept
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   result              : sum/difference, or zero-extended comparison bit
//   carryout            : final carry; for subtract-based ops 1 = no borrow
//   overflow            : signed overflow of the add/sub
//   zero                : result == 0
//
// state  | meaning
// S_IDLE | waiting for in_valid; operands latched on accept
// S_RUN  | one DIGIT-bit slice per cycle through the digit adder
// S_DONE | result and flags held until out_ready
// -----------------------------------------------------------------------------
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("serial_alu: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    op_t                r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]   r_result;
    logic               r_carryout;
    logic               r_overflow;
    logic               r_zero;

    logic [DIGIT-1:0]   w_sum;
    logic               w_cout;
    logic               w_cmsb;
    logic               w_last;
    logic               w_v;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_res_fin;

    // Operands are shifted right each cycle, so the active slice is always
    // the low DIGIT bits.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    // Sum slices enter at the top of the accumulator; after N slices the
    // first slice has reached bit 0.
    assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
    assign w_last    = (r_cnt == CNT_W'(N - 1));
    assign w_v       = w_cout ^ w_cmsb;

    always_comb begin
        w_res_fin = w_acc_nxt;
        case (r_op)
            OP_SLT:  w_res_fin = {{(WIDTH-1){1'b0}}, w_acc_nxt[WIDTH-1] ^ w_v};
            OP_SLTU: w_res_fin = {{(WIDTH-1){1'b0}}, ~w_cout};
            default: w_res_fin = w_acc_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_acc      <= '0;
            r_result   <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_op    <= op;
                        r_b     <= op_is_sub(op) ? ~b : b;
                        r_carry <= op_is_sub(op);
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result   <= w_res_fin;
                        r_carryout <= w_cout;
                        r_overflow <= w_v;
                        r_zero     <= (w_res_fin == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = r_result;
    assign carryout = r_carryout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
